// File: rtl/timing_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// timing_sequencer : one-hot T1..T4 machine-cycle strobes with T3 wait states,
//                    run/halt/single-step control and retired-instruction count
// Revision 1.0
// ------------------------------------------------------------------------
module timing_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 7
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Halt_Req,
  input  logic             Step_Mode,
  input  logic             Step,
  input  logic             Mem_Op,
  input  logic             Mem_Ready,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             T4,
  output logic             Cycle_Done,
  output logic             Halted,
  output logic             Timeout,
  output logic [3:0]       Wait_Cnt,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_T1 = 3'd1,
    S_T2 = 3'd2,
    S_T3 = 3'd3,
    S_T4 = 3'd4,
    HALT = 3'd5
  } state_t;

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  state_t           r_state;
  logic             r_timeout;
  logic [3:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_timeout     <= 1'b0;
      r_wait_cnt    <= 4'd0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Run) begin
            r_state   <= S_T1;
            r_timeout <= 1'b0;
          end
        end
        S_T1: r_state <= S_T2;
        S_T2: begin
          r_state    <= S_T3;
          r_wait_cnt <= 4'd0;
        end
        S_T3: begin
          // Mem_Ready matters only while a memory op is outstanding here
          if (!Mem_Op || Mem_Ready) begin
            r_state    <= S_T4;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt == c_max_wait) begin
            r_state    <= S_T4;
            r_wait_cnt <= 4'd0;
            r_timeout  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_T4: begin
          r_instr_count <= r_instr_count + CNT_W'(1);
          r_wait_cnt    <= 4'd0;
          if (Halt_Req || Step_Mode) r_state <= HALT;
          else                       r_state <= S_T1;
        end
        HALT: begin
          // A step exit leaves Timeout alone; only a run exit clears it
          if (Step_Mode && Step) begin
            r_state <= S_T1;
          end else if (!Step_Mode && Run && !Halt_Req) begin
            r_state   <= S_T1;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign T1          = (r_state == S_T1);
  assign T2          = (r_state == S_T2);
  assign T3          = (r_state == S_T3);
  assign T4          = (r_state == S_T4);
  assign Cycle_Done  = (r_state == S_T4);
  assign Halted      = (r_state == IDLE) || (r_state == HALT);
  assign Timeout     = r_timeout;
  assign Wait_Cnt    = r_wait_cnt;
  assign Instr_Count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_timing_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for timing_sequencer (8-bit counter so wrap is reachable).
module tb_timing_sequencer;
  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 7;

  logic clk = 1'b0;
  logic Reset, Run, Halt_Req, Step_Mode, Step, Mem_Op, Mem_Ready;
  logic T1, T2, T3, T4, Cycle_Done, Halted, Timeout;
  logic [3:0] Wait_Cnt;
  logic [CNT_W-1:0] Instr_Count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timing_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Halt_Req(Halt_Req),
    .Step_Mode(Step_Mode), .Step(Step), .Mem_Op(Mem_Op), .Mem_Ready(Mem_Ready),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4), .Cycle_Done(Cycle_Done),
    .Halted(Halted), .Timeout(Timeout), .Wait_Cnt(Wait_Cnt), .Instr_Count(Instr_Count)
  );

  // All sampling and driving happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic sync_t1();
    for (int n = 0; n < 20 && !T1; n++) tick();
    total++;
    if (T1 !== 1'b1) begin bad++; $display("FAIL sync_t1: T1=%b required 1 within 20 cycles", T1); end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Run = 1'b0; Halt_Req = 1'b0; Step_Mode = 1'b0;
    Step = 1'b0; Mem_Op = 1'b0; Mem_Ready = 1'b0;
    tick(); tick();
    total++;
    if ({T1,T2,T3,T4} !== 4'b0000) begin bad++; $display("FAIL reset_tn: got %b required 0000", {T1,T2,T3,T4}); end
    total++;
    if ({Halted,Cycle_Done,Timeout} !== 3'b100) begin bad++; $display("FAIL reset_flags: Halted/Done/Timeout=%b required 100", {Halted,Cycle_Done,Timeout}); end
    total++;
    if (Wait_Cnt !== 4'd0 || Instr_Count !== 8'd0) begin bad++; $display("FAIL reset_counts: wait=%0d count=%0d required 0/0", Wait_Cnt, Instr_Count); end
  endtask

  task automatic test_run();
    logic [3:0] exp;
    Reset = 1'b1; Run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp = 4'b1000 >> (i % 4);
      total++;
      if ({T1,T2,T3,T4} !== exp || Halted !== 1'b0 || Cycle_Done !== exp[0]) begin
        bad++; $display("FAIL run_phase[%0d]: Tn=%b Halted=%b Done=%b required %b 0 %b", i, {T1,T2,T3,T4}, Halted, Cycle_Done, exp, exp[0]);
      end
    end
    tick();
    total++;
    if (Instr_Count !== 8'd10 || T1 !== 1'b1) begin bad++; $display("FAIL run_count: count=%0d T1=%b required 10 1", Instr_Count, T1); end
  endtask

  // Runs one memory instruction from T1 to the next T1; ready_at=0 means never ready.
  task automatic mem_instr(input int ready_at, output int len, output int n3,
                           output int maxw, output logic to_t4);
    len = 0; n3 = 0; maxw = 0; to_t4 = 1'bx;
    Mem_Op = 1'b1; Mem_Ready = 1'b0;
    do begin
      if (T3) begin
        n3++;
        if (int'(Wait_Cnt) > maxw) maxw = int'(Wait_Cnt);
        if (n3 == ready_at) Mem_Ready = 1'b1;
      end
      if (T4) begin to_t4 = Timeout; Mem_Op = 1'b0; Mem_Ready = 1'b0; end
      len++;
      tick();
    end while (!T1 && len < 30);
    Mem_Op = 1'b0; Mem_Ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    int len, n3, maxw; logic to_t4; logic [CNT_W-1:0] c0;
    sync_t1();
    c0 = Instr_Count;
    mem_instr(4, len, n3, maxw, to_t4);
    total++;
    if (n3 != 4 || maxw != 3 || len != 7) begin bad++; $display("FAIL mem_wait_shape: t3=%0d wait=%0d len=%0d required 4 3 7", n3, maxw, len); end
    total++;
    if (to_t4 !== 1'b0) begin bad++; $display("FAIL mem_wait_timeout: got %b required 0", to_t4); end
    total++;
    if (Instr_Count !== c0 + 8'd1) begin bad++; $display("FAIL mem_wait_count: got %0d required %0d", Instr_Count, c0 + 8'd1); end
  endtask

  task automatic test_timeout();
    int len, n3, maxw; logic to_t4;
    sync_t1();
    mem_instr(0, len, n3, maxw, to_t4);
    total++;
    if (n3 != 8 || maxw != 7 || len != 11) begin bad++; $display("FAIL timeout_shape: t3=%0d wait=%0d len=%0d required 8 7 11", n3, maxw, len); end
    total++;
    if (to_t4 !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b required 1", to_t4); end
    repeat (8) tick();
    total++;
    if (Timeout !== 1'b1 || T1 !== 1'b1) begin bad++; $display("FAIL timeout_sticky: Timeout=%b T1=%b required 1 1", Timeout, T1); end
  endtask

  task automatic test_halt();
    logic [CNT_W-1:0] c0;
    sync_t1();
    c0 = Instr_Count;
    tick();
    Halt_Req = 1'b1;
    tick(); tick();
    total++;
    if (T4 !== 1'b1 || Cycle_Done !== 1'b1) begin bad++; $display("FAIL halt_completes: T4=%b Done=%b required 1 1", T4, Cycle_Done); end
    tick();
    total++;
    if (Halted !== 1'b1 || {T1,T2,T3,T4} !== 4'b0000) begin bad++; $display("FAIL halt_enter: Halted=%b Tn=%b required 1 0000", Halted, {T1,T2,T3,T4}); end
    total++;
    if (Instr_Count !== c0 + 8'd1 || Timeout !== 1'b1) begin bad++; $display("FAIL halt_state: count=%0d Timeout=%b required %0d 1", Instr_Count, Timeout, c0 + 8'd1); end
    repeat (3) tick();
    total++;
    if (Halted !== 1'b1) begin bad++; $display("FAIL halt_hold: Halted=%b required 1", Halted); end
    Halt_Req = 1'b0;
    tick();
    total++;
    if (T1 !== 1'b1 || Halted !== 1'b0 || Timeout !== 1'b0) begin bad++; $display("FAIL halt_resume: T1=%b Halted=%b Timeout=%b required 1 0 0", T1, Halted, Timeout); end
  endtask

  task automatic test_step();
    logic [CNT_W-1:0] c0;
    sync_t1();
    Step_Mode = 1'b1; Run = 1'b0;
    repeat (4) tick();
    total++;
    if (Halted !== 1'b1) begin bad++; $display("FAIL step_enter: Halted=%b required 1", Halted); end
    c0 = Instr_Count;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) begin
        Run = (j % 3 == 0);
        tick();
      end
      Run = 1'b0;
      total++;
      if (Halted !== 1'b1 || {T1,T2,T3,T4} !== 4'b0000) begin bad++; $display("FAIL step_wait[%0d]: Halted=%b Tn=%b required 1 0000", k, Halted, {T1,T2,T3,T4}); end
      Step = 1'b1;
      tick();
      Step = 1'b0;
      total++;
      if (T1 !== 1'b1) begin bad++; $display("FAIL step_start[%0d]: T1=%b required 1", k, T1); end
      tick(); tick(); tick();
      total++;
      if (T4 !== 1'b1) begin bad++; $display("FAIL step_t4[%0d]: T4=%b required 1", k, T4); end
      tick();
      total++;
      if (Halted !== 1'b1) begin bad++; $display("FAIL step_rehalt[%0d]: Halted=%b required 1", k, Halted); end
    end
    total++;
    if (Instr_Count !== c0 + 8'd3) begin bad++; $display("FAIL step_count: got %0d required %0d", Instr_Count, c0 + 8'd3); end
    Step_Mode = 1'b0; Step = 1'b1;
    tick();
    Step = 1'b0;
    total++;
    if (Halted !== 1'b1) begin bad++; $display("FAIL step_ignored: Halted=%b required 1", Halted); end
    Run = 1'b1;
    tick();
    total++;
    if (T1 !== 1'b1) begin bad++; $display("FAIL step_exit_run: T1=%b required 1", T1); end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 1400 && Instr_Count !== 8'hFF; n++) tick();
    total++;
    if (Instr_Count !== 8'hFF) begin bad++; $display("FAIL wrap_reach: got %0h required ff", Instr_Count); end
    for (int n = 0; n < 8 && !T4; n++) tick();
    tick();
    total++;
    if (Instr_Count !== 8'h00 || T1 !== 1'b1) begin bad++; $display("FAIL wrap_zero: count=%0h T1=%b required 00 1", Instr_Count, T1); end
  endtask

  task automatic test_reset_mid();
    sync_t1();
    Mem_Op = 1'b1; Mem_Ready = 1'b0;
    tick(); tick(); tick();
    total++;
    if (T3 !== 1'b1) begin bad++; $display("FAIL rst_mid_t3: T3=%b required 1", T3); end
    Reset = 1'b0;
    #1;
    total++;
    if ({T1,T2,T3,T4} !== 4'b0000 || Halted !== 1'b1) begin bad++; $display("FAIL rst_mid_tn: Tn=%b Halted=%b required 0000 1", {T1,T2,T3,T4}, Halted); end
    total++;
    if (Instr_Count !== 8'd0 || Wait_Cnt !== 4'd0) begin bad++; $display("FAIL rst_mid_counts: count=%0d wait=%0d required 0 0", Instr_Count, Wait_Cnt); end
    Run = 1'b0; Mem_Op = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    total++;
    if (Halted !== 1'b1) begin bad++; $display("FAIL rst_idle: Halted=%b required 1", Halted); end
    Run = 1'b1;
    tick();
    total++;
    if (T1 !== 1'b1 || Instr_Count !== 8'd0) begin bad++; $display("FAIL rst_restart: T1=%b count=%0d required 1 0", T1, Instr_Count); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_step();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
